// File: rtl/redmule_dbus_demux_if.sv
// Core-side data bus of the RedMulE demux: request channel plus in-order response.
// The demux takes the slave modport; the core (or bench) drives the master modport.
interface redmule_dbus_demux_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/redmule_dbus_demux.sv
// Data-bus demux: region-table decode, in-order outstanding tracking, error/MMIO responder.
// Optional built-in MMIO target (exit/print/cycle counter) under REDMULE_DBUS_DEMUX_MMIO_EN.
module redmule_dbus_demux #(
    parameter int unsigned              N_TGT     = 3,
    parameter int unsigned              MAX_OUT   = 4,
    // Element 0 sits at the LSB end of the packed literal.
    parameter logic [N_TGT-1:0][31:0]   TGT_BASE  = {32'h00110000, 32'h00140000, 32'h00001000},
    parameter logic [N_TGT-1:0][31:0]   TGT_SIZE  = {32'h00030000, 32'h00030000, 32'h000FF000},
    parameter logic [31:0]              MMIO_BASE = 32'h80000000,
    parameter logic [31:0]              ERR_RDATA = 32'hBADCAB1E
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    redmule_dbus_demux_if.slave     bus,
    output logic [N_TGT-1:0]        tgt_req_o,
    input  logic [N_TGT-1:0]        tgt_gnt_i,
    output logic [31:0]             tgt_addr_o,
    output logic                    tgt_we_o,
    output logic [3:0]              tgt_be_o,
    output logic [31:0]             tgt_wdata_o,
    input  logic [N_TGT-1:0]        tgt_rvalid_i,
    input  logic [N_TGT-1:0][31:0]  tgt_rdata_i,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_code_o,
    output logic                    print_valid_o,
    output logic [7:0]              print_char_o,
    output logic                    proto_err_o
);

    localparam int unsigned ID_W  = $clog2(N_TGT + 2);
    localparam int unsigned PTR_W = $clog2(MAX_OUT);

    typedef logic [ID_W-1:0] id_t;

    localparam id_t UNMAP_ID = id_t'(N_TGT + 1);
`ifdef REDMULE_DBUS_DEMUX_MMIO_EN
    localparam id_t MMIO_ID  = id_t'(N_TGT);
`else
    localparam id_t MMIO_ID  = UNMAP_ID;
`endif

    assign tgt_addr_o  = bus.addr;
    assign tgt_we_o    = bus.we;
    assign tgt_be_o    = bus.be;
    assign tgt_wdata_o = bus.wdata;

    logic [N_TGT-1:0] tgt_hit;
    logic             mmio_hit;
    id_t              sel_id;

    always_comb begin
        for (int unsigned i = 0; i < N_TGT; i++) begin
            tgt_hit[i] = ({1'b0, bus.addr} >= {1'b0, TGT_BASE[i]}) &&
                         ({1'b0, bus.addr} <  ({1'b0, TGT_BASE[i]} + {1'b0, TGT_SIZE[i]}));
        end
    end

    assign mmio_hit = ({1'b0, bus.addr} >= {1'b0, MMIO_BASE}) &&
                      ({1'b0, bus.addr} <  ({1'b0, MMIO_BASE} + 33'h100));

    // Descending scan so the lowest matching region index wins.
    always_comb begin
        sel_id = mmio_hit ? MMIO_ID : UNMAP_ID;
        for (int unsigned i = N_TGT; i > 0; i--) begin
            if (tgt_hit[i-1]) sel_id = id_t'(i - 1);
        end
    end

    id_t              fifo_id [MAX_OUT];
    logic             fifo_rd [MAX_OUT];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count;
    logic             empty, full;
    id_t              youngest_id, head_id;
    logic             head_rd;

    assign empty       = (count == '0);
    assign full        = (count == (PTR_W+1)'(MAX_OUT));
    assign youngest_id = fifo_id[wptr - PTR_W'(1)];
    assign head_id     = fifo_id[rptr];
    assign head_rd     = fifo_rd[rptr];

    logic order_ok, avail, is_ext, accept, pop;

    // The FIFO only ever holds one id, so responses cannot overtake each other.
    assign order_ok = empty || (sel_id == youngest_id);
    assign avail    = bus.req && !full && order_ok;
    assign is_ext   = (sel_id < id_t'(N_TGT));

    always_comb begin
        for (int unsigned k = 0; k < N_TGT; k++) begin
            tgt_req_o[k] = avail && (sel_id == id_t'(k));
        end
    end

    assign accept  = is_ext ? |(tgt_req_o & tgt_gnt_i) : avail;
    assign bus.gnt = accept;

    logic        int_valid, int_err;
    logic [31:0] int_rdata, int_rdata_next;

    logic             head_ext, ext_rvalid;
    logic [31:0]      ext_rdata;
    logic [N_TGT-1:0] exp_mask;

    always_comb begin
        head_ext   = 1'b0;
        ext_rvalid = 1'b0;
        ext_rdata  = '0;
        exp_mask   = '0;
        for (int unsigned k = 0; k < N_TGT; k++) begin
            if (!empty && head_id == id_t'(k)) begin
                head_ext    = 1'b1;
                ext_rvalid  = tgt_rvalid_i[k];
                ext_rdata   = tgt_rdata_i[k];
                exp_mask[k] = 1'b1;
            end
        end
    end

    assign bus.rvalid = !empty && (head_ext ? ext_rvalid : int_valid);
    assign bus.rdata  = !bus.rvalid ? '0 :
                        head_ext    ? ext_rdata :
                        head_rd     ? int_rdata : '0;
    assign bus.err    = bus.rvalid && !head_ext && int_err;
    assign pop        = bus.rvalid;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_id[wptr] <= sel_id;
            fifo_rd[wptr] <= !bus.we;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + PTR_W'(1);
            if (pop)    rptr <= rptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
        end
    end

`ifdef REDMULE_DBUS_DEMUX_MMIO_EN
    logic [31:0] cycle_cnt;
    logic [5:0]  mmio_word;
    logic        mmio_wr;

    assign mmio_word = bus.addr[7:2] - MMIO_BASE[7:2];
    assign mmio_wr   = accept && (sel_id == MMIO_ID) && bus.we;

    always_comb begin
        int_rdata_next = ERR_RDATA;
        if (sel_id == MMIO_ID) int_rdata_next = (mmio_word == 6'd0) ? cycle_cnt : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt     <= '0;
            exit_valid_o  <= 1'b0;
            exit_code_o   <= '0;
            print_valid_o <= 1'b0;
            print_char_o  <= '0;
        end else begin
            cycle_cnt     <= cycle_cnt + 32'd1;
            print_valid_o <= mmio_wr && (mmio_word == 6'd1);
            if (mmio_wr && mmio_word == 6'd0) begin
                exit_valid_o <= 1'b1;
                exit_code_o  <= bus.wdata;
            end
            if (mmio_wr && mmio_word == 6'd1) print_char_o <= bus.wdata[7:0];
        end
    end
`else
    assign int_rdata_next = ERR_RDATA;
    assign exit_valid_o   = 1'b0;
    assign exit_code_o    = '0;
    assign print_valid_o  = 1'b0;
    assign print_char_o   = '0;
`endif

    // One-entry internal responder: answers exactly one cycle after each accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_valid <= 1'b0;
            int_err   <= 1'b0;
            int_rdata <= '0;
        end else begin
            int_valid <= accept && !is_ext;
            if (accept && !is_ext) begin
                int_err   <= (sel_id == UNMAP_ID);
                int_rdata <= int_rdata_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) proto_err_o <= 1'b0;
        else if (|(tgt_rvalid_i & ~exp_mask)) proto_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_redmule_dbus_demux.sv
// Directed self-checking bench for redmule_dbus_demux with default parameters.
// MMIO expectations follow whether REDMULE_DBUS_DEMUX_MMIO_EN is defined.
module tb_redmule_dbus_demux;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [2:0]        tgt_req, tgt_gnt, tgt_rvalid;
    logic [2:0][31:0]  tgt_rdata;
    logic [31:0]       tgt_addr, tgt_wdata, exit_code;
    logic              tgt_we, exit_valid, print_valid, proto_err;
    logic [3:0]        tgt_be;
    logic [7:0]        print_char;
    int                n_chk = 0;
    int                n_fail = 0;

    redmule_dbus_demux_if bus ();

    redmule_dbus_demux dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .tgt_req_o    (tgt_req),
        .tgt_gnt_i    (tgt_gnt),
        .tgt_addr_o   (tgt_addr),
        .tgt_we_o     (tgt_we),
        .tgt_be_o     (tgt_be),
        .tgt_wdata_o  (tgt_wdata),
        .tgt_rvalid_i (tgt_rvalid),
        .tgt_rdata_i  (tgt_rdata),
        .exit_valid_o (exit_valid),
        .exit_code_o  (exit_code),
        .print_valid_o(print_valid),
        .print_char_o (print_char),
        .proto_err_o  (proto_err)
    );

    always #5 clk = ~clk;

`ifdef REDMULE_DBUS_DEMUX_MMIO_EN
    int unsigned cyc;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata);
        bus.req   = req;
        bus.addr  = addr;
        bus.we    = we;
        bus.be    = 4'hF;
        bus.wdata = wdata;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt    = '0;
        tgt_rvalid = '0;
        tgt_rdata  = '0;

        // Reset state
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_err", bus.err, 0);
        check("rst_tgt_req", tgt_req, 0);
        check("rst_exit_valid", exit_valid, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_print_valid", print_valid, 0);
        check("rst_print_char", print_char, 0);
        check("rst_proto_err", proto_err, 0);
        step(); step();
        rst_ni = 1'b1;

        // Single read of target 2 through a one-cycle memory
        step();
        drive(1'b1, 32'h00110010, 1'b0, 32'hCAFE0001);
        tgt_gnt = 3'b100;
        #1;
        check("t2_tgt_req", tgt_req, 3'b100);
        check("t2_gnt", bus.gnt, 1);
        check("t2_bcast_addr", tgt_addr, 32'h00110010);
        check("t2_bcast_wdata", tgt_wdata, 32'hCAFE0001);
        check("t2_bcast_be", tgt_be, 4'hF);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        tgt_rvalid = 3'b100;
        tgt_rdata[2] = 32'h12345678;
        #1;
        check("t2_rvalid", bus.rvalid, 1);
        check("t2_rdata", bus.rdata, 32'h12345678);
        check("t2_err", bus.err, 0);
        step();
        tgt_rvalid = '0;
        #1;
        check("t2_idle_rvalid", bus.rvalid, 0);

        // Fill the outstanding FIFO on target 1, then a fifth request
        tgt_gnt = 3'b010;
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 32'h00140000 + 32'(4 * i), 1'b0, 32'h0);
            #1;
            check("fill_gnt", bus.gnt, 1);
        end
        step();
        drive(1'b1, 32'h00140010, 1'b0, 32'h0);
        #1;
        check("full_gnt", bus.gnt, 0);
        check("full_tgt_req", tgt_req, 3'b000);
        step();
        tgt_rvalid = 3'b010;
        tgt_rdata[1] = 32'h000000A0;
        #1;
        check("full_pop_rvalid", bus.rvalid, 1);
        check("full_pop_rdata", bus.rdata, 32'h000000A0);
        check("full_no_bypass_gnt", bus.gnt, 0);
        step();
        tgt_rvalid = '0;
        #1;
        check("fifth_gnt", bus.gnt, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        for (int i = 1; i <= 4; i++) begin
            tgt_rvalid = 3'b010;
            tgt_rdata[1] = 32'h000000A0 + 32'(i);
            #1;
            check("burst_rvalid", bus.rvalid, 1);
            check("burst_rdata", bus.rdata, 32'h000000A0 + 32'(i));
            step();
        end
        tgt_rvalid = '0;
        #1;
        check("burst_drained", bus.rvalid, 0);

        // Switching target waits for the outstanding response
        step();
        drive(1'b1, 32'h00140020, 1'b0, 32'h0);
        tgt_gnt = 3'b110;
        #1;
        check("sw_t1_gnt", bus.gnt, 1);
        step();
        drive(1'b1, 32'h00110000, 1'b0, 32'h0);
        #1;
        check("sw_blocked_req", tgt_req, 3'b000);
        check("sw_blocked_gnt", bus.gnt, 0);
        step();
        tgt_rvalid = 3'b010;
        tgt_rdata[1] = 32'h000000B1;
        #1;
        check("sw_t1_rdata", bus.rdata, 32'h000000B1);
        check("sw_still_blocked", bus.gnt, 0);
        step();
        tgt_rvalid = '0;
        #1;
        check("sw_t2_req", tgt_req, 3'b100);
        check("sw_t2_gnt", bus.gnt, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        tgt_rvalid = 3'b100;
        tgt_rdata[2] = 32'h000000C2;
        #1;
        check("sw_t2_rdata", bus.rdata, 32'h000000C2);
        step();
        tgt_rvalid = '0;

        // Unmapped: back-to-back reads then a write
        drive(1'b1, 32'h90000000, 1'b0, 32'h0);
        #1;
        check("um_gnt", bus.gnt, 1);
        check("um_tgt_req", tgt_req, 3'b000);
        step();
        #1;
        check("um_rvalid", bus.rvalid, 1);
        check("um_err", bus.err, 1);
        check("um_rdata", bus.rdata, 32'hBADCAB1E);
        check("um_b2b_gnt", bus.gnt, 1);
        step();
        drive(1'b1, 32'h90000000, 1'b1, 32'h00000055);
        #1;
        check("um_rd2_rdata", bus.rdata, 32'hBADCAB1E);
        check("um_wr_gnt", bus.gnt, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("um_wr_rvalid", bus.rvalid, 1);
        check("um_wr_err", bus.err, 1);
        step();
        #1;
        check("um_idle", bus.rvalid, 0);
        check("um_no_exit", exit_valid, 0);
        check("um_no_print", print_valid, 0);

        // MMIO window
`ifdef REDMULE_DBUS_DEMUX_MMIO_EN
        drive(1'b1, 32'h80000004, 1'b1, 32'h00000041);
        #1;
        check("pr_gnt", bus.gnt, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("pr_valid", print_valid, 1);
        check("pr_char", print_char, 32'h41);
        check("pr_rvalid", bus.rvalid, 1);
        check("pr_err", bus.err, 0);
        step();
        #1;
        check("pr_pulse_end", print_valid, 0);
        drive(1'b1, 32'h80000000, 1'b1, 32'h00000000);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("exit_valid", exit_valid, 1);
        check("exit_code", exit_code, 0);
        for (int i = 0; i < 200 && cyc < 100; i++) step();
        check("cnt_reach", cyc, 100);
        drive(1'b1, 32'h80000000, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("cnt_rdata", bus.rdata, 100);
        check("cnt_err", bus.err, 0);
        step();
`else
        drive(1'b1, 32'h80000000, 1'b0, 32'h0);
        #1;
        check("mm_off_gnt", bus.gnt, 1);
        step();
        drive(1'b1, 32'h80000004, 1'b1, 32'h00000041);
        #1;
        check("mm_off_err", bus.err, 1);
        check("mm_off_rdata", bus.rdata, 32'hBADCAB1E);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("mm_off_wr_err", bus.err, 1);
        check("mm_off_print", print_valid, 0);
        step();
        #1;
        check("mm_off_char", print_char, 0);
        check("mm_off_exit", exit_valid, 0);
`endif

        // Response from the wrong target is dropped and flagged
        drive(1'b1, 32'h00140000, 1'b0, 32'h0);
        tgt_gnt = 3'b010;
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        tgt_rvalid = 3'b001;
        tgt_rdata[0] = 32'hDEADBEEF;
        #1;
        check("stray_rvalid", bus.rvalid, 0);
        step();
        tgt_rvalid = '0;
        #1;
        check("stray_proto", proto_err, 1);

        // Reset in the middle of outstanding traffic
        drive(1'b1, 32'h00140004, 1'b0, 32'h0);
        tgt_gnt = 3'b010;
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_rdata", bus.rdata, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_tgt_req", tgt_req, 0);
        check("mid_rst_proto", proto_err, 0);
        check("mid_rst_exit", exit_valid, 0);
        check("mid_rst_code", exit_code, 0);
        check("mid_rst_char", print_char, 0);
        step();
        rst_ni = 1'b1;
        step();
        tgt_rvalid = 3'b010;
        tgt_rdata[1] = 32'h11111111;
        #1;
        check("late_rvalid", bus.rvalid, 0);
        step();
        tgt_rvalid = '0;
        #1;
        check("late_proto", proto_err, 1);
        step(); step(); step();
        #1;
        check("proto_sticky", proto_err, 1);
        drive(1'b1, 32'h00110000, 1'b0, 32'h0);
        tgt_gnt = 3'b100;
        #1;
        check("post_rst_gnt", bus.gnt, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tgt_gnt = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
